lsu: RTL and testbench

Load/store unit for the multi-cycle RV32I core. Accepts one memory instruction from the control sequencer in EXECUTE, validates alignment, drives a word-addressed data-memory request/ready handshake, and produces the sign- or zero-extended load result for the register file's WRITE_BACK. While a transfer is outstanding it holds `busy`, and the control FSM keeps the core in MEM_WAIT.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_if.sv | 22 ++
 rtl/lsu_align.sv | 79 +++++++
 rtl/lsu.sv | 127 ++++++++++++
 tb/tb_lsu.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store unit
package lsu_pkg;

  localparam int DATA_W = 32;

  // RV32I load/store width and sign field
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Trap cause codes, shared with the trap/CSR block
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

  // Fields of an accepted request that are still needed after IDLE
  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] offset;
    logic [4:0] rd;
  } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - word-addressed data-memory request/ready bus
interface lsu_if;

  logic                       mem_req;
  logic                       mem_we;
  logic [lsu_pkg::DATA_W-1:0] mem_addr;
  logic [3:0]                 mem_wstrb;
  logic [lsu_pkg::DATA_W-1:0] mem_wdata;
  logic                       mem_ready;
  logic [lsu_pkg::DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering, load extraction and request checks
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Reject unsupported widths first; alignment only matters for legal widths
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (is_load) begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end else if (is_store) begin
      illegal = (funct3 >= 3'b011);
    end
    if (!illegal) begin
      case (funct3[1:0])
        2'b01:   misaligned = offset[0];
        2'b10:   misaligned = (offset != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Replicate narrow store data across lanes so the strobe alone picks the bytes
  always_comb begin
    wstrb = 4'b0000;
    wdata = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << offset;
        end
        2'b01: begin
          wdata = {2{store_data[15:0]}};
          wstrb = offset[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata = store_data;
          wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Pick the addressed byte/half from the read word and extend it
  always_comb begin
    case (offset)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_data = {24'h000000, lane_b};
      F3_HU:   load_data = {16'h0000, lane_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit FSM and registers for the multi-cycle RV32I core
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  lsu_if.master           bus,
  output logic            busy,
  output logic            done,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            trap,
  output logic [3:0]      trap_cause,
  output logic [XLEN-1:0] trap_addr
);

  logic [1:0] state;
  lsu_req_t   req_q;
  logic       trap_q;

  logic        sel_load;
  logic        sel_store;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misaligned;
  logic        al_illegal;
  logic        accept;

  // While idle the checker looks at the live request; afterwards at the latched one
  assign sel_load  = (state == ST_IDLE) ? is_load  : req_q.is_load;
  assign sel_store = (state == ST_IDLE) ? is_store : !req_q.is_load;
  assign sel_f3    = (state == ST_IDLE) ? funct3   : req_q.funct3;
  assign sel_off   = (state == ST_IDLE) ? addr[1:0] : req_q.offset;

  assign accept = (state == ST_IDLE) && start && (is_load || is_store);

  lsu_align u_align (
    .is_load    (sel_load),
    .is_store   (sel_store),
    .funct3     (sel_f3),
    .offset     (sel_off),
    .store_data (store_data),
    .rdata      (bus.mem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);
  assign trap     = done && trap_q;
  assign wb_valid = done && !trap_q && req_q.is_load && (req_q.rd != 5'd0);

  // Sequence IDLE -> REQ -> FIN, or IDLE -> FIN directly for a trapping request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_q         <= '0;
      trap_q        <= 1'b0;
      trap_cause    <= 4'd0;
      trap_addr     <= '0;
      wb_rd         <= 5'd0;
      wb_data       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wstrb <= 4'b0000;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q <= '{is_load: is_load, funct3: funct3, offset: addr[1:0], rd: rd_in};
            if (al_illegal || al_misaligned) begin
              trap_q     <= 1'b1;
              trap_cause <= al_illegal ? CAUSE_ILLEGAL :
                            (is_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN);
              trap_addr  <= addr;
              state      <= ST_FIN;
            end else begin
              trap_q        <= 1'b0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= is_store;
              bus.mem_addr  <= {addr[XLEN-1:2], 2'b00};
              bus.mem_wstrb <= al_wstrb;
              bus.mem_wdata <= al_wdata;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.mem_ready) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wstrb <= 4'b0000;
            if (req_q.is_load) begin
              wb_data <= al_load;
              wb_rd   <= req_q.rd;
            end
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          trap_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - table-driven and randomized self-checking bench for lsu
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done, wb_valid, trap;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, trap_addr;
  logic [3:0]  trap_cause;

  lsu_if bus ();

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .trap       (trap),
    .trap_cause (trap_cause),
    .trap_addr  (trap_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        ld;
    bit        st;
    bit [2:0]  f3;
    bit [31:0] a;
    bit [31:0] sd;
    bit [4:0]  rd;
    bit [31:0] rdata;
    int        waits;
    int        poke;
  } op_t;

  typedef struct {
    int        done_cyc;
    bit        trap;
    bit [3:0]  cause;
    bit        req;
    bit [31:0] maddr;
    bit        we;
    bit [3:0]  wstrb;
    bit [31:0] wdata;
    bit        wbv;
    bit [31:0] wbd;
  } exp_t;

  typedef struct {
    op_t  o;
    exp_t e;
  } vec_t;

  typedef struct {
    int        done_cyc;
    int        req_first;
    int        req_cnt;
    bit        stable;
    bit [31:0] maddr;
    bit        we;
    bit [3:0]  wstrb;
    bit [31:0] wdata;
    bit        trap;
    bit [3:0]  cause;
    bit [31:0] taddr;
    int        trap_cnt;
    int        wbv_cnt;
    bit [4:0]  wbr;
    bit [31:0] wbd;
    bit        busy_ok;
    bit        tail_quiet;
  } obs_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Reference: access size, legality and lane arithmetic straight from the ISA rules
  function automatic exp_t model(input op_t o);
    exp_t e;
    int sz, off;
    bit sgn, legal;
    bit [31:0] v, mask;
    e.done_cyc = 0; e.trap = 0; e.cause = 0; e.req = 0; e.maddr = 0;
    e.we = 0; e.wstrb = 0; e.wdata = 0; e.wbv = 0; e.wbd = 0;
    off = int'(o.a % 4);
    sz = 1; sgn = 0; legal = 0;
    case (o.f3)
      3'd0: begin sz = 1; sgn = 1; legal = 1; end
      3'd1: begin sz = 2; sgn = 1; legal = 1; end
      3'd2: begin sz = 4; sgn = 0; legal = 1; end
      3'd4: begin sz = 1; sgn = 0; legal = o.ld; end
      3'd5: begin sz = 2; sgn = 0; legal = o.ld; end
      default: legal = 0;
    endcase
    if (!legal) begin
      e.trap = 1; e.cause = 4'd2; e.done_cyc = 1;
    end else if (off % sz != 0) begin
      e.trap = 1; e.cause = o.ld ? 4'd4 : 4'd6; e.done_cyc = 1;
    end else begin
      e.req = 1;
      e.done_cyc = 2 + o.waits;
      e.maddr = o.a - 32'(off);
      e.we = o.st;
      if (o.st) begin
        e.wstrb = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = o.sd[8*(i % sz) +: 8];
      end else begin
        v = o.rdata >> (8 * off);
        if (sz < 4) begin
          mask = (32'd1 << (8 * sz)) - 32'd1;
          v = v & mask;
          if (sgn && v[8*sz-1]) v = v | ~mask;
        end
        e.wbd = v;
        e.wbv = (o.rd != 0);
      end
    end
    return e;
  endfunction

  // Issue one request, play memory with the given wait count, observe until done
  task automatic run_op(input op_t o, output obs_t r);
    int  wcnt;
    bit  got;
    r.done_cyc = 0; r.req_first = 0; r.req_cnt = 0; r.stable = 1; r.maddr = 0;
    r.we = 0; r.wstrb = 0; r.wdata = 0; r.trap = 0; r.cause = 0; r.taddr = 0;
    r.trap_cnt = 0; r.wbv_cnt = 0; r.wbr = 0; r.wbd = 0; r.busy_ok = 1; r.tail_quiet = 1;
    wcnt = 0;
    got = 0;
    start = 1; is_load = o.ld; is_store = o.st; funct3 = o.f3;
    addr = o.a; store_data = o.sd; rd_in = o.rd;
    @(posedge clk); #1;
    is_load = 0; funct3 = 3'($urandom); addr = $urandom; store_data = $urandom; rd_in = 5'($urandom);
    for (int cyc = 1; cyc <= 24 && !got; cyc++) begin
      start = (cyc == o.poke);
      is_store = (cyc == o.poke);
      if (cyc == o.poke) begin funct3 = F3_W; addr = 32'h500; end
      if (bus.mem_req) begin
        bus.mem_ready = (wcnt == o.waits);
        bus.mem_rdata = (wcnt == o.waits) ? o.rdata : $urandom;
        wcnt++;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      if (bus.mem_req) begin
        if (r.req_cnt == 0) begin
          r.req_first = cyc; r.maddr = bus.mem_addr; r.we = bus.mem_we;
          r.wstrb = bus.mem_wstrb; r.wdata = bus.mem_wdata;
        end else if (r.maddr != bus.mem_addr || r.we != bus.mem_we ||
                     r.wstrb != bus.mem_wstrb || r.wdata != bus.mem_wdata) begin
          r.stable = 0;
        end
        r.req_cnt++;
      end
      if (!busy) r.busy_ok = 0;
      if (trap) r.trap_cnt++;
      if (wb_valid) r.wbv_cnt++;
      if (done) begin
        got = 1; r.done_cyc = cyc; r.trap = trap; r.cause = trap_cause;
        r.taddr = trap_addr; r.wbr = wb_rd; r.wbd = wb_data;
      end
      @(posedge clk); #1;
    end
    for (int t = 0; t < 3; t++) begin
      start = 0; is_store = 0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.mem_req || done || busy || trap || wb_valid) r.tail_quiet = 0;
      @(posedge clk); #1;
    end
    bus.mem_ready = 0;
  endtask

  task automatic compare(input string tag, input op_t o, input exp_t e, input obs_t r);
    chk($sformatf("%s done_cycle", tag), 32'(r.done_cyc), 32'(e.done_cyc));
    chk($sformatf("%s trap", tag), 32'(r.trap), 32'(e.trap));
    chk($sformatf("%s trap_pulses", tag), 32'(r.trap_cnt), 32'(e.trap));
    chk($sformatf("%s busy_held", tag), 32'(r.busy_ok), 32'd1);
    chk($sformatf("%s quiet_after", tag), 32'(r.tail_quiet), 32'd1);
    chk($sformatf("%s req_cycles", tag), 32'(r.req_cnt), e.req ? 32'(e.done_cyc - 1) : 32'd0);
    chk($sformatf("%s wb_valid_pulses", tag), 32'(r.wbv_cnt), 32'(e.wbv));
    if (e.trap) begin
      chk($sformatf("%s trap_cause", tag), 32'(r.cause), 32'(e.cause));
      chk($sformatf("%s trap_addr", tag), r.taddr, o.a);
    end
    if (e.req) begin
      chk($sformatf("%s req_first", tag), 32'(r.req_first), 32'd1);
      chk($sformatf("%s req_stable", tag), 32'(r.stable), 32'd1);
      chk($sformatf("%s mem_addr", tag), r.maddr, e.maddr);
      chk($sformatf("%s mem_we", tag), 32'(r.we), 32'(e.we));
      chk($sformatf("%s mem_wstrb", tag), 32'(r.wstrb), 32'(e.wstrb));
      if (o.st) chk($sformatf("%s mem_wdata", tag), r.wdata, e.wdata);
    end
    if (e.wbv) begin
      chk($sformatf("%s wb_rd", tag), 32'(r.wbr), 32'(o.rd));
      chk($sformatf("%s wb_data", tag), r.wbd, e.wbd);
    end
  endtask

  initial begin
    vec_t tbl[13];
    obs_t r;
    op_t  o;
    int   bad;

    bus.mem_ready = 0;
    bus.mem_rdata = 0;

    #12;
    chk("reset mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset flags", {28'd0, busy, done, wb_valid, trap}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset wb_rd", 32'(wb_rd), 32'd0);
    chk("reset trap_cause", 32'(trap_cause), 32'd0);
    chk("reset trap_addr", trap_addr, 32'd0);

    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    start = 1; is_load = 0; is_store = 0; addr = 32'h100;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("no_op start busy", 32'(busy), 32'd0);
    chk("no_op start mem_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;

    //         ld st f3     addr        store_data    rd    rdata        w  p      done tr cause req maddr     we wstrb  wdata         wbv wbd
    tbl[0]  = '{'{0, 1, F3_W,  32'h100, 32'hDEADBEEF, 5'd0, 32'h0,        0, 0}, '{2, 0, 4'd0, 1, 32'h100, 1, 4'hF, 32'hDEADBEEF, 0, 32'h0}};
    tbl[1]  = '{'{1, 0, F3_B,  32'h203, 32'h0,        5'd5, 32'h80123456, 3, 0}, '{5, 0, 4'd0, 1, 32'h200, 0, 4'h0, 32'h0,        1, 32'hFFFFFF80}};
    tbl[2]  = '{'{1, 0, F3_BU, 32'h203, 32'h0,        5'd5, 32'h80123456, 3, 0}, '{5, 0, 4'd0, 1, 32'h200, 0, 4'h0, 32'h0,        1, 32'h00000080}};
    tbl[3]  = '{'{0, 1, F3_H,  32'h102, 32'h0000ABCD, 5'd0, 32'h0,        0, 0}, '{2, 0, 4'd0, 1, 32'h100, 1, 4'hC, 32'hABCDABCD, 0, 32'h0}};
    tbl[4]  = '{'{1, 0, F3_HU, 32'h102, 32'h0,        5'd7, 32'h12345678, 1, 0}, '{3, 0, 4'd0, 1, 32'h100, 0, 4'h0, 32'h0,        1, 32'h00001234}};
    tbl[5]  = '{'{1, 0, F3_W,  32'h101, 32'h0,        5'd3, 32'h0,        0, 0}, '{1, 1, 4'd4, 0, 32'h0,   0, 4'h0, 32'h0,        0, 32'h0}};
    tbl[6]  = '{'{0, 1, F3_W,  32'h102, 32'h11223344, 5'd0, 32'h0,        0, 0}, '{1, 1, 4'd6, 0, 32'h0,   0, 4'h0, 32'h0,        0, 32'h0}};
    tbl[7]  = '{'{0, 1, 3'd4,  32'h100, 32'h11223344, 5'd0, 32'h0,        0, 0}, '{1, 1, 4'd2, 0, 32'h0,   0, 4'h0, 32'h0,        0, 32'h0}};
    tbl[8]  = '{'{1, 0, F3_W,  32'h104, 32'h0,        5'd0, 32'h5A5A5A5A, 2, 0}, '{4, 0, 4'd0, 1, 32'h104, 0, 4'h0, 32'h0,        0, 32'h0}};
    tbl[9]  = '{'{1, 0, F3_W,  32'h40,  32'h0,        5'd9, 32'hCAFEF00D, 4, 2}, '{6, 0, 4'd0, 1, 32'h40,  0, 4'h0, 32'h0,        1, 32'hCAFEF00D}};
    tbl[10] = '{'{1, 0, F3_H,  32'h100, 32'h0,        5'd3, 32'h00008001, 0, 0}, '{2, 0, 4'd0, 1, 32'h100, 0, 4'h0, 32'h0,        1, 32'hFFFF8001}};
    tbl[11] = '{'{0, 1, F3_B,  32'h101, 32'h12345678, 5'd0, 32'h0,        1, 0}, '{3, 0, 4'd0, 1, 32'h100, 1, 4'h2, 32'h78787878, 0, 32'h0}};
    tbl[12] = '{'{1, 0, 3'd3,  32'h0,   32'h0,        5'd1, 32'h0,        0, 1}, '{1, 1, 4'd2, 0, 32'h0,   0, 4'h0, 32'h0,        0, 32'h0}};

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].o, r);
      compare($sformatf("vec%0d", i), tbl[i].o, tbl[i].e, r);
    end

    // Reset while a load waits in REQ: mem_req must fall before any clock edge
    start = 1; is_load = 1; funct3 = F3_W; addr = 32'h40; rd_in = 5'd4; bus.mem_ready = 0;
    @(posedge clk); #1;
    start = 0; is_load = 0;
    @(negedge clk);
    chk("rst_mid mem_req before", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("rst_mid mem_req async", 32'(bus.mem_req), 32'd0);
    chk("rst_mid busy async", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    bus.mem_ready = 1;
    bus.mem_rdata = 32'h13579BDF;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || wb_valid || bus.mem_req || busy) bad++;
    end
    chk("rst_mid late ready ignored", 32'(bad), 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 0;

    for (int n = 0; n < 80; n++) begin
      o.ld = 1'($urandom_range(0, 1));
      o.st = !o.ld;
      o.f3 = 3'($urandom);
      o.a = $urandom;
      o.sd = $urandom;
      o.rd = 5'($urandom);
      o.rdata = $urandom;
      o.waits = $urandom_range(0, 3);
      o.poke = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_op(o, r);
      compare($sformatf("rand%0d", n), o, model(o), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
